bus_owner_arbiter: RTL

- Shares one tri-state data bus between N_REQ requesters, e.g. CPU core, OAM DMA and a debug port.
- The bus is fitted with a weak keeper cell that holds the last driven value while nobody drives.
- The block grants ownership round-robin, produces per-requester drive enables, and enforces a turnaround gap in which no one drives. Two drivers never overlap, and the keeper holds the bus during the gap.
- An optional hold limit preempts an owner that monopolises the bus while others wait.

---
 rtl/bus_owner_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/bus_owner_arbiter.sv
// Round-robin owner arbiter for a shared tri-state bus with a keeper cell.
// Ownership always ends in a TURN gap so two drivers can never overlap.
module bus_owner_arbiter #(
    parameter int N_REQ       = 3,
    parameter int TURN_CYCLES = 1,
    parameter int MAX_HOLD    = 0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [N_REQ-1:0]         drv_en,
    output logic [$clog2(N_REQ)-1:0] owner,
    output logic                     bus_floating,
    output logic                     preempt
);

    localparam int              OW        = $clog2(N_REQ);
    localparam logic [N_REQ-1:0] ONE      = N_REQ'(1);
    localparam logic [7:0]      HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [2:0]      TURN_LAST = 3'(TURN_CYCLES - 1);
    localparam logic [OW-1:0]   LAST_IDX  = OW'(N_REQ - 1);

    typedef enum logic [1:0] {IDLE, OWN, TURN} state_t;

    state_t           state, state_n;
    logic [N_REQ-1:0] gnt_n;
    logic [N_REQ-1:0] others;
    logic [OW-1:0]    owner_n;
    logic [OW-1:0]    winner;
    logic             found;
    logic [7:0]       hold_cnt, hold_n;
    logic [2:0]       turn_cnt, turn_n;
    logic             preempt_n;

    // Indices above the last owner win first, then the wrap-around part,
    // which leaves the previous owner with the lowest priority.
    always_comb begin
        found  = 1'b0;
        winner = owner;
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j > int'(owner))) begin
                found  = 1'b1;
                winner = OW'(j);
            end
        end
        for (int j = 0; j < N_REQ; j++) begin
            if (!found && req[j] && (j <= int'(owner))) begin
                found  = 1'b1;
                winner = OW'(j);
            end
        end
    end

    assign others = req & ~(ONE << owner);

    always_comb begin
        state_n   = state;
        gnt_n     = gnt;
        owner_n   = owner;
        hold_n    = hold_cnt;
        turn_n    = turn_cnt;
        preempt_n = 1'b0;
        case (state)
            IDLE: begin
                gnt_n = '0;
                if (found) begin
                    state_n = OWN;
                    gnt_n   = ONE << winner;
                    owner_n = winner;
                    hold_n  = 8'd0;
                end
            end
            OWN: begin
                // A normal release takes precedence over a simultaneous preemption.
                if (!req[owner]) begin
                    state_n = TURN;
                    gnt_n   = '0;
                    turn_n  = 3'd0;
                end else if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && (|others)) begin
                    state_n   = TURN;
                    gnt_n     = '0;
                    turn_n    = 3'd0;
                    preempt_n = 1'b1;
                end else if (hold_cnt != 8'hFF) begin
                    hold_n = hold_cnt + 8'd1;
                end
            end
            TURN: begin
                gnt_n = '0;
                if (turn_cnt == TURN_LAST) begin
                    if (found) begin
                        state_n = OWN;
                        gnt_n   = ONE << winner;
                        owner_n = winner;
                        hold_n  = 8'd0;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    turn_n = turn_cnt + 3'd1;
                end
            end
            default: begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            gnt      <= '0;
            drv_en   <= '0;
            owner    <= LAST_IDX;
            hold_cnt <= 8'd0;
            turn_cnt <= 3'd0;
            preempt  <= 1'b0;
        end else begin
            state    <= state_n;
            gnt      <= gnt_n;
            drv_en   <= gnt_n;
            owner    <= owner_n;
            hold_cnt <= hold_n;
            turn_cnt <= turn_n;
            preempt  <= preempt_n;
        end
    end

    assign bus_floating = ~|drv_en;

endmodule
